fpcmult_seq: RTL
================

// Module: fpcmult_seq
// PURPOSE
//  Fixed-point signed complex multiplier c = a*b (or c = a*conj(b)), selected per transaction.
//  One iterative shift-add real multiplier is time-shared over the four real products
//  ar*br, ac*bc, ar*bc, ac*br. Final adds wrap or saturate, with an overflow flag.
//  Area-lean successor to the three-multiplier complex multiplier; same val/rdy stream contract.
// PARAMETERS
//  n    32  total bit width of every operand and result (two's complement)
//  d    16  fractional bits (Qn-d.d); 0 <= d < n
//  SAT  0   0: final add/sub wraps mod 2^n; 1: final add/sub clamps to max/min signed n-bit
// PORTS
//  clk        in   1  clock; all state updates on the rising edge
//  reset      in   1  synchronous, active-high
//  recv_val   in   1  input transaction valid
//  recv_rdy   out  1  block can accept a transaction
//  recv_conj  in   1  1: multiply by conj(b); sampled with the operands
//  ar,ac      in   n  real and imaginary parts of a
//  br,bc      in   n  real and imaginary parts of b
//  send_val   out  1  result valid
//  send_rdy   in   1  consumer ready
//  cr,cc      out  n  real and imaginary parts of the result; stable while send_val=1
//  ovf        out  1  valid with send_val: final add/sub of cr or cc overflowed n bits
// BEHAVIOUR
//  Reset: state=IDLE; recv_rdy=1, send_val=0, cr=cc=0, ovf=0; product index=0; bit counter=0.
//   Reset mid-operation aborts the transaction and discards the result.
//  FSM IDLE -> CALC -> DONE:
//   IDLE: recv_rdy=1. On recv_val&recv_rdy, latch ar,ac,br,bc,recv_conj; clear accumulators; go to CALC.
//   CALC: recv_rdy=0, send_val=0. Compute products k=0..3 in the order above, exactly n cycles each.
//    Go to DONE after 4n CALC cycles.
//   DONE: send_val=1; cr,cc,ovf held. On send_rdy=1 the result is consumed: next state is CALC
//    if recv_val=1 (back-to-back), else IDLE.
//  recv_rdy = (state==IDLE) | (state==DONE & send_rdy). This is a combinational path from send_rdy.
//  Latency: accept on edge t -> send_val=1 from edge t+4n. Throughput is 1 result per 4n+1 cycles
//   under back-to-back operation.
//  Input changes after acceptance have no effect. send_rdy is ignored outside DONE.
//  Product rule: form the full 2n-bit signed product P of the two n-bit operands.
//   The fixed-point product is p = P[n+d-1:d]: arithmetic shift right by d (truncates toward -inf),
//   keeping the low n bits. Bits above n+d-1 are discarded (wrap); this does not set ovf.
//   Operand -2^(n-1) is legal; compute its magnitude in n+1 bits.
//  Result normal mode (recv_conj=0):  cr = arbr - acbc;  cc = arbc + acbr.
//  Result conj mode (recv_conj=1):    cr = arbr + acbc;  cc = acbr - arbc.
//  Final add/sub is done in n+1 bits; an overflow of either cr or cc sets ovf=1.
//   SAT=1: an overflowed result is clamped to 2^(n-1)-1 or -2^(n-1) by true sign.
//   SAT=0: keep the low n bits.
//  cr, cc and ovf update only on the CALC->DONE edge; they keep their last values in IDLE.
// TESTING  (n=32, d=16 unless stated)
//  1. Normal mode: ar=00018000, ac=00020000, br=00008000, bc=FFFF0000, conj=0
//     -> cr=0002C000, cc=FFFF8000, ovf=0; send_val rises exactly 128 cycles after accept.
//  2. Conj mode: same operands, conj=1 -> cr=FFFEC000, cc=00028000, ovf=0.
//  3. Overflow: ar=ac=br=00960000, bc=FF6A0000, conj=0
//     -> SAT=1: cr=7FFFFFFF, cc=0, ovf=1;  SAT=0: cr=AFC80000, cc=0, ovf=1.
//  4. Backpressure: hold send_rdy=0 for 20 cycles in DONE -> send_val, cr, cc stable; recv_rdy=0.
//     Then raise send_rdy with recv_val=1 -> new operands accepted on the same edge; no cycle lost.
//  5. Reset mid-CALC (cycle 50) -> next cycle recv_rdy=1, send_val=0, cr=cc=0.
//     A new transaction then produces the correct result.
//  6. Edge operands: ar=br=80000000, ac=bc=0 -> cr = P[47:16] of (+2^62) = 00000000 (wrap), ovf=0.
//     Random regression vs a bit-accurate model for n=16/d=8 and n=32/d=16, both SAT values.

Source files
------------

// File: rtl/fpcmult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpcmult_seq
// Purpose  : Sequential fixed-point signed complex multiplier.
//            c = a*b (recv_conj=0) or c = a*conj(b) (recv_conj=1).
//            A single shift-add real multiplier is reused for the four real
//            products ar*br, ac*bc, ar*bc, ac*br, taking n cycles each.
//            The final add/sub wraps (SAT=0) or clamps (SAT=1), and ovf
//            reports an overflow of either result.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            recv_val/recv_rdy    - input handshake (recv_rdy is combinational
//                                   from send_rdy while in DONE)
//            recv_conj            - conjugate-b select, latched with operands
//            ar, ac, br, bc       - operands, Q(n-d).d two's complement
//            send_val/send_rdy    - output handshake
//            cr, cc, ovf          - result and overflow, held while send_val=1
// Revision : 1.0 - initial release
// ============================================================================
module fpcmult_seq #(
  parameter int n   = 32,
  parameter int d   = 16,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic         recv_conj,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc,
  output logic         ovf
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [n-1:0]   ar_q, ac_q, br_q, bc_q;
  logic           conj_q;
  logic [1:0]     k_q;
  logic [CW-1:0]  cnt_q;
  logic [2*n-1:0] acc_q, mcand_q;
  logic [n:0]     mplr_q;
  logic [n-1:0]   p0_q, p1_q, p2_q;
  logic [n-1:0]   cr_q, cc_q;
  logic           ovf_q;

  logic           accept_w, last_bit_w, last_w, first_w;
  logic [n-1:0]   x_w, y_w;
  logic [n:0]     xm_w, ym_w;
  logic [2*n-1:0] mcand_cur_w, acc_cur_w, sum_w, prod_full_w;
  logic [n:0]     mplr_cur_w;
  logic [n-1:0]   p_w;
  logic [n:0]     sr_w, si_w;
  logic           ovr_w, ovi_w;
  logic [n-1:0]   cr_d, cc_d;
  logic           unused_prod_bits;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    case (state_q)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) state_d = CALC;
      end
      CALC: begin
        if (last_w) state_d = DONE;
      end
      DONE: begin
        send_val = 1'b1;
        recv_rdy = send_rdy;
        if (send_rdy) state_d = recv_val ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept_w   = recv_val & recv_rdy;
  assign first_w    = (cnt_q == '0);
  assign last_bit_w = (cnt_q == CNT_LAST);
  assign last_w     = last_bit_w && (k_q == 2'd3);

  // ------------------------------------------------ shift-add datapath
  always_comb begin
    case (k_q)
      2'd0:    begin x_w = ar_q; y_w = br_q; end
      2'd1:    begin x_w = ac_q; y_w = bc_q; end
      2'd2:    begin x_w = ar_q; y_w = bc_q; end
      default: begin x_w = ac_q; y_w = br_q; end
    endcase
  end

  // Magnitudes need n+1 bits so that -2^(n-1) becomes +2^(n-1).
  assign xm_w = x_w[n-1] ? -{x_w[n-1], x_w} : {x_w[n-1], x_w};
  assign ym_w = y_w[n-1] ? -{y_w[n-1], y_w} : {y_w[n-1], y_w};

  // On the first bit of each product the fresh magnitudes are used directly,
  // so no separate load cycle is needed between products.
  assign mcand_cur_w = first_w ? {{(n-1){1'b0}}, xm_w} : mcand_q;
  assign mplr_cur_w  = first_w ? ym_w : mplr_q;
  assign acc_cur_w   = first_w ? '0 : acc_q;
  assign sum_w       = acc_cur_w + (mplr_cur_w[0] ? mcand_cur_w : '0);

  // Only meaningful on the last bit of a product.
  assign prod_full_w = (x_w[n-1] ^ y_w[n-1]) ? -sum_w : sum_w;
  assign p_w         = prod_full_w[n+d-1:d];
  assign unused_prod_bits = ^prod_full_w;

  // ------------------------------------------------ final add/sub
  always_comb begin
    logic [n:0] e0, e1, e2, e3;
    e0 = {p0_q[n-1], p0_q};
    e1 = {p1_q[n-1], p1_q};
    e2 = {p2_q[n-1], p2_q};
    e3 = {p_w[n-1],  p_w};
    sr_w  = conj_q ? (e0 + e1) : (e0 - e1);
    si_w  = conj_q ? (e3 - e2) : (e2 + e3);
    ovr_w = sr_w[n] ^ sr_w[n-1];
    ovi_w = si_w[n] ^ si_w[n-1];
    cr_d  = sr_w[n-1:0];
    cc_d  = si_w[n-1:0];
    // Bit n of the wide sum is the true sign used for clamping.
    if (SAT != 0 && ovr_w) cr_d = sr_w[n] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    if (SAT != 0 && ovi_w) cc_d = si_w[n] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
  end

  // ------------------------------------------------ datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_q <= '0; ac_q <= '0; br_q <= '0; bc_q <= '0;
      conj_q  <= 1'b0;
      k_q     <= 2'd0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      p0_q <= '0; p1_q <= '0; p2_q <= '0;
      cr_q <= '0; cc_q <= '0; ovf_q <= 1'b0;
    end else if (accept_w) begin
      ar_q <= ar; ac_q <= ac; br_q <= br; bc_q <= bc;
      conj_q  <= recv_conj;
      k_q     <= 2'd0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else if (state_q == CALC) begin
      acc_q   <= sum_w;
      mcand_q <= {mcand_cur_w[2*n-2:0], 1'b0};
      mplr_q  <= {1'b0, mplr_cur_w[n:1]};
      if (last_bit_w) begin
        cnt_q <= '0;
        k_q   <= k_q + 2'd1;
        case (k_q)
          2'd0:    p0_q <= p_w;
          2'd1:    p1_q <= p_w;
          2'd2:    p2_q <= p_w;
          default: begin
            cr_q  <= cr_d;
            cc_q  <= cc_d;
            ovf_q <= ovr_w | ovi_w;
          end
        endcase
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign cr  = cr_q;
  assign cc  = cc_q;
  assign ovf = ovf_q;

endmodule
`default_nettype wire
